lane_stream_ctrl: RTL and testbench
===================================

LANE_STREAM_CTRL -- requirements
Module: lane_stream_ctrl

Interface
REQ-001 SHALL have parameters: GENE_SZ, default 64, gene width; ATTR_SZ, default 8, count/address width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one genome pass
- node_cnt  in  ATTR_SZ  number of node genes
- conn_cnt  in  ATTR_SZ  number of connection genes
- rd_base  in  ATTR_SZ  source base address
- wr_base  in  ATTR_SZ  destination base address
- rd_en  out  1  source memory read strobe
- rd_addr  out  ATTR_SZ  source address
- rd_data  in  GENE_SZ  source data, valid 1 cycle after rd_en
- lane_clr  out  1  clear pulse to the mutation lane reset
- lane_state  out  2  lane phase: 00 node, 10 conn, 11 idle
- lane_gene  out  GENE_SZ  gene to lane
- lane_gene_out  in  GENE_SZ  lane result, registered in lane
- lane_valid  in  1  lane result kept
- wr_en  out  1  destination write strobe
- wr_addr  out  ATTR_SZ  destination address
- wr_data  out  GENE_SZ  destination data
- out_node_cnt  out  ATTR_SZ  surviving node genes
- out_conn_cnt  out  ATTR_SZ  surviving connection genes
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

Function
REQ-003 SHALL implement states IDLE, CLEAR, NODE, CONN, DRAIN, DONE.
REQ-004 IDLE: start=1 SHALL latch all four count/base inputs, zero out_node_cnt/out_conn_cnt and wr_addr←wr_base, and go to CLEAR; start in any other state SHALL be ignored.
REQ-005 CLEAR SHALL last one cycle with lane_clr=1, then go to NODE if node_cnt≠0, else CONN if conn_cnt≠0, else DRAIN.
REQ-006 NODE SHALL assert rd_en with rd_addr=rd_base+i for i=0..node_cnt-1, one per cycle, then go to CONN if conn_cnt≠0, else DRAIN.
REQ-007 CONN SHALL assert rd_en with rd_addr=rd_base+node_cnt+j for j=0..conn_cnt-1, one per cycle, then go to DRAIN.
REQ-008 DRAIN SHALL last exactly 2 cycles, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-009 Address arithmetic SHALL be modulo 2^ATTR_SZ (wrap-around, no error).
REQ-010 Each issued read SHALL carry a phase tag (node/conn) and a valid bit through a 2-stage register pipeline.
REQ-011 Stage 1 (cycle after read): lane_gene=rd_data; lane_state=00 for a node tag, 10 for a conn tag, 11 if there is no valid tag.
REQ-012 Stage 2: wr_en=lane_valid AND stage-2 valid (combinational); wr_data=lane_gene_out; lane_valid without a stage-2 tag SHALL be ignored.
REQ-013 Each wr_en cycle SHALL increment wr_addr and also increment out_node_cnt for a node tag, or out_conn_cnt for a conn tag.
REQ-014 The node→conn transition SHALL insert no bubble; the last node gene and the first conn gene SHALL occupy consecutive cycles.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 out_node_cnt/out_conn_cnt SHALL hold their values from DONE until the next accepted start.
REQ-017 lane_gene SHALL be 0 whenever lane_state=11.

Reset
REQ-018 rst=1 SHALL asynchronously force: IDLE; all pipeline valid bits 0; rd_en, wr_en, lane_clr, busy, done = 0; lane_state=11; rd_addr, wr_addr, lane_gene, wr_data, out counts = 0.
REQ-019 rst mid-pass SHALL abandon the pass, with no further writes after deassertion until a new start.

Verification
REQ-020 node_cnt=3, conn_cnt=4, rd_base=0x10, lane keeps all genes -> reads 0x10..0x16 on consecutive cycles; 7 writes from wr_base; out_node_cnt=3, out_conn_cnt=4; done 10 cycles after the start-accept cycle.
REQ-021 Lane drops node #1 and conn #0,#2 -> writes are contiguous (wr_base..wr_base+3); out_node_cnt=2, out_conn_cnt=2.
REQ-022 node_cnt=0, conn_cnt=0 -> CLEAR, DRAIN(2), DONE; no rd_en, no wr_en; counts 0.
REQ-023 rd_base=0xFE, node_cnt=2, conn_cnt=2 -> rd_addr sequence FE, FF, 00, 01.
REQ-024 start pulsed while busy -> ignored; in-progress counts and addresses unchanged.
REQ-025 rst asserted in the 2nd CONN cycle -> all outputs reach reset values immediately; a following start runs a clean pass starting with a lane_clr pulse.

Source files
------------

// File: rtl/lane_stream_ctrl.sv
// lane_stream_ctrl: streams node then connection genes through a mutation lane and compacts kept results into destination memory
module lane_stream_ctrl #(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ATTR_SZ-1:0] node_cnt,
  input  logic [ATTR_SZ-1:0] conn_cnt,
  input  logic [ATTR_SZ-1:0] rd_base,
  input  logic [ATTR_SZ-1:0] wr_base,
  output logic               rd_en,
  output logic [ATTR_SZ-1:0] rd_addr,
  input  logic [GENE_SZ-1:0] rd_data,
  output logic               lane_clr,
  output logic [1:0]         lane_state,
  output logic [GENE_SZ-1:0] lane_gene,
  input  logic [GENE_SZ-1:0] lane_gene_out,
  input  logic               lane_valid,
  output logic               wr_en,
  output logic [ATTR_SZ-1:0] wr_addr,
  output logic [GENE_SZ-1:0] wr_data,
  output logic [ATTR_SZ-1:0] out_node_cnt,
  output logic [ATTR_SZ-1:0] out_conn_cnt,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, CLEAR, NODE, CONN, DRAIN, DONE} state_t;
  localparam logic [ATTR_SZ-1:0] ONE = 1;
  state_t state, next;
  logic [ATTR_SZ-1:0] idx, node_n, conn_n, base;
  logic s1_v, s1_t, s2_v, s2_t, last;
  always_comb begin
    next = state;
    last = idx == ((state == NODE) ? node_n : conn_n) - ONE;
    unique case (state)
      IDLE:    next = start ? CLEAR : IDLE;
      CLEAR:   next = (node_n != '0) ? NODE : (conn_n != '0) ? CONN : DRAIN;
      NODE:    next = !last ? NODE : (conn_n != '0) ? CONN : DRAIN;
      CONN:    next = last ? DRAIN : CONN;
      DRAIN:   next = (idx == ONE) ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign rd_en      = state == NODE || state == CONN;
  assign rd_addr    = rd_en ? base + ((state == CONN) ? node_n : '0) + idx : '0;
  assign lane_clr   = state == CLEAR;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign lane_state = s1_v ? {s1_t, 1'b0} : 2'b11;
  assign lane_gene  = s1_v ? rd_data : '0;
  assign wr_en      = lane_valid & s2_v;
  assign wr_data    = s2_v ? lane_gene_out : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      node_n       <= '0;
      conn_n       <= '0;
      base         <= '0;
      wr_addr      <= '0;
      out_node_cnt <= '0;
      out_conn_cnt <= '0;
      s1_v         <= 1'b0;
      s1_t         <= 1'b0;
      s2_v         <= 1'b0;
      s2_t         <= 1'b0;
    end else begin
      state <= next;
      idx   <= (next != state) ? '0 : idx + ONE;
      s1_v  <= rd_en;
      s1_t  <= state == CONN;
      s2_v  <= s1_v;
      s2_t  <= s1_t;
      if (state == IDLE && start) begin
        node_n       <= node_cnt;
        conn_n       <= conn_cnt;
        base         <= rd_base;
        wr_addr      <= wr_base;
        out_node_cnt <= '0;
        out_conn_cnt <= '0;
      end else if (wr_en) begin
        wr_addr      <= wr_addr + ONE;
        out_node_cnt <= s2_t ? out_node_cnt : out_node_cnt + ONE;
        out_conn_cnt <= s2_t ? out_conn_cnt + ONE : out_conn_cnt;
      end
    end
  end
endmodule

// File: tb/tb_lane_stream_ctrl.sv
// tb_lane_stream_ctrl: scoreboard bench with a source memory model and a scripted keep/drop mutation lane
module tb_lane_stream_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] node_cnt = '0, conn_cnt = '0, rd_base = '0, wr_base = '0;
  logic rd_en, lane_clr, lane_valid, wr_en, busy, done;
  logic [7:0] rd_addr, wr_addr, out_node_cnt, out_conn_cnt;
  logic [1:0] lane_state;
  logic [63:0] rd_data, lane_gene, lane_gene_out, wr_data;
  int checks = 0, failures = 0;
  logic [71:0] wq[$];
  logic [7:0] rq[$];
  logic [31:0] nmask = '0, cmask = '0;
  int nidx = 0, cidx = 0;
  lane_stream_ctrl #(.GENE_SZ(64), .ATTR_SZ(8)) dut (
    .clk(clk), .rst(rst), .start(start), .node_cnt(node_cnt), .conn_cnt(conn_cnt),
    .rd_base(rd_base), .wr_base(wr_base), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .lane_clr(lane_clr), .lane_state(lane_state), .lane_gene(lane_gene),
    .lane_gene_out(lane_gene_out), .lane_valid(lane_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_node_cnt(out_node_cnt), .out_conn_cnt(out_conn_cnt),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mem_val(logic [7:0] a);
    return {24'hABCDEF, a, 24'h135799, ~a};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data       <= '0;
      lane_gene_out <= '0;
      lane_valid    <= 1'b0;
      nidx          <= 0;
      cidx          <= 0;
    end else begin
      rd_data       <= rd_en ? mem_val(rd_addr) : {$urandom(), $urandom()};
      lane_gene_out <= ~lane_gene;
      if (lane_clr) begin
        nidx       <= 0;
        cidx       <= 0;
        lane_valid <= 1'b0;
      end else if (lane_state == 2'b00) begin
        lane_valid <= !nmask[nidx];
        nidx       <= nidx + 1;
      end else if (lane_state == 2'b10) begin
        lane_valid <= !cmask[cidx];
        cidx       <= cidx + 1;
      end else
        lane_valid <= 1'($urandom_range(0, 1));
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: read at 0x%02h, none required", rd_addr);
        end else begin
          logic [7:0] ea;
          ea = rq.pop_front();
          if (rd_addr !== ea) begin
            failures++;
            $display("FAIL rd_addr: got 0x%02h, required 0x%02h", rd_addr, ea);
          end
        end
      end
      if (wr_en) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected: write 0x%02h=0x%016h, none required", wr_addr, wr_data);
        end else begin
          logic [71:0] ew;
          ew = wq.pop_front();
          if ({wr_addr, wr_data} !== ew) begin
            failures++;
            $display("FAIL wr: got 0x%02h=0x%016h, required 0x%02h=0x%016h", wr_addr, wr_data, ew[71:64], ew[63:0]);
          end
        end
      end
      if (lane_state == 2'b11) begin
        checks++;
        if (lane_gene !== '0) begin
          failures++;
          $display("FAIL lane_gene_idle: got 0x%016h, required 0", lane_gene);
        end
      end
    end
  end
  task automatic run_pass(input logic [7:0] nc, cc, rb, wb, input logic [31:0] nm, cm, input bit poke);
    int k = 0, en = 0, ec = 0, got = -1;
    nmask = nm;
    cmask = cm;
    for (int i = 0; i < int'(nc); i++) begin
      rq.push_back(8'(rb + i));
      if (!nm[i]) begin
        wq.push_back({8'(wb + k), ~mem_val(8'(rb + i))});
        k++;
        en++;
      end
    end
    for (int j = 0; j < int'(cc); j++) begin
      rq.push_back(8'(rb + nc + j));
      if (!cm[j]) begin
        wq.push_back({8'(wb + k), ~mem_val(8'(rb + nc + j))});
        k++;
        ec++;
      end
    end
    @(negedge clk);
    node_cnt = nc;
    conn_cnt = cc;
    rd_base = rb;
    wr_base = wb;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        checks++;
        if ({lane_clr, busy} !== 2'b11) begin
          failures++;
          $display("FAIL clear_cycle: lane_clr,busy=%b, required 11", {lane_clr, busy});
        end
      end
      if (poke && c == 4) begin
        start = 1'b1;
        node_cnt = ~nc;
        conn_cnt = 8'd9;
        rd_base = 8'h55;
        wr_base = 8'h77;
      end
      if (poke && c == 5) start = 1'b0;
      if (done) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got != 3 + int'(nc) + int'(cc)) begin
      failures++;
      $display("FAIL done_latency: got %0d, required %0d", got, 3 + int'(nc) + int'(cc));
    end
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL leftover: reads=%0d writes=%0d pending, required 0", rq.size(), wq.size());
    end
    rq.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_node_cnt, out_conn_cnt} !== {1'b0, 8'(en), 8'(ec)}) begin
      failures++;
      $display("FAIL counts: busy=%b node=%0d conn=%0d, required busy=0 node=%0d conn=%0d", busy, out_node_cnt, out_conn_cnt, en, ec);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rd_en, wr_en, lane_clr, done, lane_state, rd_addr, wr_addr, out_node_cnt, out_conn_cnt} !== {5'b0, 2'b11, 32'b0}) begin
      failures++;
      $display("FAIL reset_ctrl: got 0x%h, required 0x%h", {busy, rd_en, wr_en, lane_clr, done, lane_state, rd_addr, wr_addr, out_node_cnt, out_conn_cnt}, {5'b0, 2'b11, 32'b0});
    end
    checks++;
    if ({lane_gene, wr_data} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data: lane_gene=0x%016h wr_data=0x%016h, required 0", lane_gene, wr_data);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    run_pass(8'd3, 8'd4, 8'h10, 8'h80, '0, '0, 1'b0);
  endtask
  task automatic test_drop;
    run_pass(8'd3, 8'd4, 8'h10, 8'h90, 32'b010, 32'b0101, 1'b0);
  endtask
  task automatic test_empty;
    run_pass(8'd0, 8'd0, 8'h33, 8'h44, '0, '0, 1'b0);
  endtask
  task automatic test_wrap;
    run_pass(8'd2, 8'd2, 8'hFE, 8'hFE, '0, '0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_pass(8'd1, 8'd1, 8'h05, 8'h20, '0, 32'b1, 1'b0);
    run_pass(8'd4, 8'd0, 8'h60, 8'h21, 32'b1001, '0, 1'b0);
  endtask
  task automatic test_busy_start;
    run_pass(8'd3, 8'd4, 8'h30, 8'hA0, 32'b100, 32'b0010, 1'b1);
  endtask
  task automatic test_mid_reset;
    nmask = '0;
    cmask = '0;
    for (int i = 0; i < 6; i++) begin
      rq.push_back(8'(8'h20 + i));
      wq.push_back({8'(8'h40 + i), ~mem_val(8'(8'h20 + i))});
    end
    @(negedge clk);
    node_cnt = 8'd2;
    conn_cnt = 8'd4;
    rd_base = 8'h20;
    wr_base = 8'h40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, rd_en, wr_en, lane_clr, done, lane_state, rd_addr, wr_addr, out_node_cnt, out_conn_cnt} !== {5'b0, 2'b11, 32'b0}) begin
      failures++;
      $display("FAIL midrst_ctrl: got 0x%h, required 0x%h", {busy, rd_en, wr_en, lane_clr, done, lane_state, rd_addr, wr_addr, out_node_cnt, out_conn_cnt}, {5'b0, 2'b11, 32'b0});
    end
    checks++;
    if ({lane_gene, wr_data} !== 128'b0) begin
      failures++;
      $display("FAIL midrst_data: lane_gene=0x%016h wr_data=0x%016h, required 0", lane_gene, wr_data);
    end
    rq.delete();
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: busy=%b, required 0", busy);
    end
    run_pass(8'd2, 8'd4, 8'h20, 8'h40, '0, 32'b1000, 1'b0);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_drop;
    test_empty;
    test_wrap;
    test_back_to_back;
    test_busy_start;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
